dma_req_arbiter: RTL and testbench

DMA_REQ_ARBITER -- requirements
Module: dma_req_arbiter

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_rr_pick.sv | 27 ++
 rtl/dma_req_arbiter.sv | 123 ++++++++++++
 tb/tb_dma_req_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA request arbiter slice.
package dma_pkg;

   localparam int NUM_CH  = 4;
   localparam int CH_ID_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_BUSY,
      ST_ACK
   } dma_state_e;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin search: first eligible channel after last_id, wrapping.
module dma_rr_pick
   import dma_pkg::*;
(
   input  logic [NUM_CH-1:0]  eligible,
   input  logic [CH_ID_W-1:0] last_id,
   output logic               any,
   output logic [CH_ID_W-1:0] pick_id
);

   logic [CH_ID_W-1:0] idx;

   // Offsets 1..NUM_CH from last_id; the final offset wraps back onto last_id itself.
   always_comb begin
      any     = 1'b0;
      pick_id = '0;
      idx     = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = last_id + CH_ID_W'(i);
         if (!any && eligible[idx]) begin
            any     = 1'b1;
            pick_id = idx;
         end
      end
   end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter between four peripheral DMA request lines with four-phase acknowledge.
module dma_req_arbiter
   import dma_pkg::*;
#(
   parameter int NUM_CH = 4
)
(
   input  logic              ACLK_i,
   input  logic              axi_m_rstn_i,
   input  logic              SYNC_P0_REQ_i,
   input  logic              SYNC_P1_REQ_i,
   input  logic              SYNC_P2_REQ_i,
   input  logic              SYNC_P3_REQ_i,
   input  logic              sync_dma_soft_rst_i,
   input  logic [NUM_CH-1:0] arb_ch_en_i,
   output logic              arb_grant_valid_o,
   output logic [1:0]        arb_grant_id_o,
   input  logic              arb_grant_ready_i,
   input  logic              dma_xfer_done_i,
   input  logic              dma_xfer_error_i,
   output logic              arb_busy_o,
   output logic              arb_err_o,
   output logic              DMA_P0_ACK_o,
   output logic              DMA_P1_ACK_o,
   output logic              DMA_P2_ACK_o,
   output logic              DMA_P3_ACK_o
);

   dma_state_e         state;
   logic [NUM_CH-1:0]  req;
   logic [NUM_CH-1:0]  eligible;
   logic [NUM_CH-1:0]  ack_q;
   logic [CH_ID_W-1:0] grant_id_q;
   logic [CH_ID_W-1:0] last_id_q;
   logic [CH_ID_W-1:0] pick_id;
   logic               pick_any;
   logic               valid_q;
   logic               busy_q;
   logic               err_q;

   assign req      = {SYNC_P3_REQ_i, SYNC_P2_REQ_i, SYNC_P1_REQ_i, SYNC_P0_REQ_i};
   assign eligible = req & arb_ch_en_i & ~ack_q;

   dma_rr_pick u_pick (
      .eligible (eligible),
      .last_id  (last_id_q),
      .any      (pick_any),
      .pick_id  (pick_id)
   );

   // Acknowledge bits drop on their own once the peripheral releases its request,
   // whatever the FSM is doing; a completion sets only the granted channel's bit.
   always_ff @(posedge ACLK_i or negedge axi_m_rstn_i) begin
      if (!axi_m_rstn_i) begin
         state      <= ST_IDLE;
         valid_q    <= 1'b0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_q      <= '0;
         last_id_q  <= CH_ID_W'(NUM_CH - 1);
      end else if (sync_dma_soft_rst_i) begin
         state      <= ST_IDLE;
         valid_q    <= 1'b0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         ack_q      <= '0;
         last_id_q  <= CH_ID_W'(NUM_CH - 1);
      end else begin
         err_q <= 1'b0;
         ack_q <= ack_q & req;
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  state      <= ST_GRANT;
                  grant_id_q <= pick_id;
                  valid_q    <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            // Acceptance wins over a withdrawal seen in the same cycle.
            ST_GRANT: begin
               if (valid_q && arb_grant_ready_i) begin
                  state     <= ST_BUSY;
                  valid_q   <= 1'b0;
                  last_id_q <= grant_id_q;
               end else if (!(req[grant_id_q] && arb_ch_en_i[grant_id_q])) begin
                  state   <= ST_IDLE;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            ST_BUSY: begin
               if (dma_xfer_done_i || dma_xfer_error_i) begin
                  state  <= ST_ACK;
                  busy_q <= 1'b0;
                  err_q  <= dma_xfer_error_i;
                  if (req[grant_id_q]) begin
                     ack_q[grant_id_q] <= 1'b1;
                  end
               end
            end
            ST_ACK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign arb_grant_valid_o = valid_q;
   assign arb_grant_id_o    = grant_id_q;
   assign arb_busy_o        = busy_q;
   assign arb_err_o         = err_q;
   assign DMA_P0_ACK_o      = ack_q[0];
   assign DMA_P1_ACK_o      = ack_q[1];
   assign DMA_P2_ACK_o      = ack_q[2];
   assign DMA_P3_ACK_o      = ack_q[3];

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: accepted grant ids go through a scoreboard queue.
module tb_dma_req_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req = 4'b0000;
   logic       soft_rst = 1'b0;
   logic [3:0] ch_en = 4'hF;
   logic       grant_ready = 1'b0;
   logic       xfer_done = 1'b0;
   logic       xfer_error = 1'b0;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       busy;
   logic       err;
   logic [3:0] ack;

   int total = 0;
   int bad = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   dma_req_arbiter #(.NUM_CH(4)) dut (
      .ACLK_i              (clk),
      .axi_m_rstn_i        (rst_n),
      .SYNC_P0_REQ_i       (req[0]),
      .SYNC_P1_REQ_i       (req[1]),
      .SYNC_P2_REQ_i       (req[2]),
      .SYNC_P3_REQ_i       (req[3]),
      .sync_dma_soft_rst_i (soft_rst),
      .arb_ch_en_i         (ch_en),
      .arb_grant_valid_o   (grant_valid),
      .arb_grant_id_o      (grant_id),
      .arb_grant_ready_i   (grant_ready),
      .dma_xfer_done_i     (xfer_done),
      .dma_xfer_error_i    (xfer_error),
      .arb_busy_o          (busy),
      .arb_err_o           (err),
      .DMA_P0_ACK_o        (ack[0]),
      .DMA_P1_ACK_o        (ack[1]),
      .DMA_P2_ACK_o        (ack[2]),
      .DMA_P3_ACK_o        (ack[3])
   );

   // Monitor: on the falling edge, a valid&ready pair means a handshake at the next rising edge.
   always @(negedge clk) begin : monitor
      int e;
      if (rst_n && grant_valid === 1'b1 && grant_ready === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL accepted_grant: got id %0d but nothing expected", grant_id);
         end else begin
            e = exp_q.pop_front();
            if (grant_id !== 2'(e)) begin
               bad++;
               $display("[TB] FAIL accepted_grant: got id %0d expected %0d", grant_id, e);
            end
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check_output({tag, "_valid"}, 32'(grant_valid), 0);
      check_output({tag, "_id"}, 32'(grant_id), 0);
      check_output({tag, "_busy"}, 32'(busy), 0);
      check_output({tag, "_err"}, 32'(err), 0);
      check_output({tag, "_ack"}, 32'(ack), 0);
   endtask

   task automatic wait_grant(input int exp_id);
      int n = 0;
      while (grant_valid !== 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      check_output("grant_valid_seen", 32'(grant_valid), 1);
      check_output("grant_id", 32'(grant_id), 32'(exp_id));
   endtask

   task automatic apply_stimulus_accept(input int exp_id);
      exp_q.push_back(exp_id);
      grant_ready = 1'b1;
      tick(1);
      grant_ready = 1'b0;
      check_output("valid_after_accept", 32'(grant_valid), 0);
      check_output("busy_after_accept", 32'(busy), 1);
   endtask

   task automatic apply_stimulus_complete(input bit with_done, input bit with_err);
      xfer_done  = with_done;
      xfer_error = with_err;
      tick(1);
      xfer_done  = 1'b0;
      xfer_error = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : stimulus
      int order[5] = '{0, 1, 2, 3, 0};

      #2 rst_n = 1'b0;
      #10;
      check_cleared("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick(1);

      // Single request on P2: one-cycle grant latency, ack follows done, clears after req drops.
      req = 4'b0100;
      tick(1);
      check_output("p2_latency_valid", 32'(grant_valid), 1);
      check_output("p2_latency_id", 32'(grant_id), 2);
      check_output("p2_busy_grant", 32'(busy), 1);
      tick(1);
      check_output("p2_valid_held", 32'(grant_valid), 1);
      apply_stimulus_accept(2);
      tick(4);
      apply_stimulus_complete(1'b1, 1'b0);
      check_output("p2_ack_set", 32'(ack), 32'h4);
      check_output("p2_busy_done", 32'(busy), 0);
      check_output("p2_no_err", 32'(err), 0);
      tick(1);
      check_output("p2_ack_held", 32'(ack), 32'h4);
      check_output("p2_no_regrant", 32'(grant_valid), 0);
      req = 4'b0000;
      tick(1);
      check_output("p2_ack_cleared", 32'(ack), 0);

      // Completion pulses while idle do nothing.
      apply_stimulus_complete(1'b1, 1'b1);
      check_output("idle_pulse_err", 32'(err), 0);
      check_output("idle_pulse_busy", 32'(busy), 0);
      check_output("idle_pulse_ack", 32'(ack), 0);

      // Soft reset restores channel 0 priority, then full fairness rotation.
      soft_rst = 1'b1;
      tick(1);
      soft_rst = 1'b0;
      check_cleared("soft_reset_idle");
      req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         wait_grant(order[i]);
         apply_stimulus_accept(order[i]);
         apply_stimulus_complete(1'b1, 1'b0);
         check_output("rr_ack_set", 32'(ack), 32'(4'b0001 << order[i]));
         req[order[i]] = 1'b0;
         tick(1);
         check_output("rr_ack_cleared", 32'(ack), 0);
         req[order[i]] = 1'b1;
      end
      req = 4'b0000;
      tick(2);
      check_output("rr_quiet", 32'(grant_valid), 0);

      // Withdrawal before acceptance: no ack, last_id stays on channel 0.
      req = 4'b0010;
      tick(1);
      check_output("wd_valid", 32'(grant_valid), 1);
      check_output("wd_id", 32'(grant_id), 1);
      req = 4'b0000;
      tick(1);
      check_output("wd_valid_drop", 32'(grant_valid), 0);
      check_output("wd_busy_drop", 32'(busy), 0);
      tick(3);
      check_output("wd_no_ack", 32'(ack), 0);

      // Channel 1 must win over 2 if last_id was untouched; finish with done+error together.
      req = 4'b0110;
      wait_grant(1);
      apply_stimulus_accept(1);
      apply_stimulus_complete(1'b1, 1'b1);
      check_output("err_pulse", 32'(err), 1);
      check_output("err_ack", 32'(ack), 32'h2);
      req = 4'b0000;
      tick(1);
      check_output("err_pulse_end", 32'(err), 0);
      check_output("err_ack_cleared", 32'(ack), 0);
      tick(1);

      // Soft reset while busy on channel 0 with ack[3] still high.
      req = 4'b1000;
      wait_grant(3);
      apply_stimulus_accept(3);
      apply_stimulus_complete(1'b1, 1'b0);
      check_output("sr_ack3", 32'(ack), 32'h8);
      req = 4'b1001;
      wait_grant(0);
      apply_stimulus_accept(0);
      check_output("sr_ack3_in_busy", 32'(ack), 32'h8);
      soft_rst = 1'b1;
      tick(1);
      soft_rst = 1'b0;
      check_cleared("sr_busy");
      wait_grant(0);
      req = 4'b0000;
      tick(2);
      check_output("sr_withdrawn_valid", 32'(grant_valid), 0);
      check_output("sr_withdrawn_busy", 32'(busy), 0);

      // Enable mask gates channel 2 until its bit is set.
      ch_en = 4'b1011;
      req   = 4'b0100;
      tick(3);
      check_output("mask_blocked", 32'(grant_valid), 0);
      ch_en = 4'hF;
      tick(1);
      check_output("mask_open_valid", 32'(grant_valid), 1);
      check_output("mask_open_id", 32'(grant_id), 2);
      apply_stimulus_accept(2);
      apply_stimulus_complete(1'b1, 1'b0);
      check_output("mask_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      tick(2);
      check_output("mask_ack_cleared", 32'(ack), 0);

      check_output("scoreboard_drained", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
